// File: rtl/tetris_line_clear_engine_if.sv
// Port bundle for tetris_line_clear_engine: board edit/clear requests, renderer
// read port and result counters. The engine uses the slave side.
interface tetris_line_clear_engine_if #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int CELL_W  = 4
);
  logic                         cell_we;
  logic [$clog2(BOARD_H)-1:0]   cell_row;
  logic [$clog2(BOARD_W)-1:0]   cell_col;
  logic [CELL_W-1:0]            cell_val;
  logic                         clear_start;
  logic                         clear_board;
  logic [3:0]                   level;
  logic [$clog2(BOARD_H)-1:0]   rd_row;
  logic [BOARD_W*CELL_W-1:0]    rd_data;
  logic                         busy;
  logic                         done;
  logic [$clog2(BOARD_H+1)-1:0] last_lines;
  logic [15:0]                  lines_total;
  logic [31:0]                  score;

  modport master (
    output cell_we, cell_row, cell_col, cell_val, clear_start, clear_board, level, rd_row,
    input  rd_data, busy, done, last_lines, lines_total, score
  );

  modport slave (
    input  cell_we, cell_row, cell_col, cell_val, clear_start, clear_board, level, rd_row,
    output rd_data, busy, done, last_lines, lines_total, score
  );
endinterface

// File: rtl/tetris_line_clear_engine.sv
// Tetris line-clear engine: drops full rows and compacts the board one row per clock, then scores.
// Latency BOARD_H+k+1 cycles, done one cycle later; requests arriving while busy are dropped.
module tetris_line_clear_engine #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int CELL_W  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  tetris_line_clear_engine_if.slave  bus
);
  localparam int ROW_W = $clog2(BOARD_H);
  localparam int COL_W = $clog2(BOARD_W);
  localparam int K_W   = $clog2(BOARD_H + 1);
  localparam int RW    = BOARD_W * CELL_W;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] FILL  = 2'd2;
  localparam logic [1:0] SCORE = 2'd3;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(BOARD_H - 1);
  localparam logic [ROW_W:0]   H_LIM    = (ROW_W + 1)'(BOARD_H);

  logic [RW-1:0]    board [BOARD_H];
  logic [1:0]       state;
  logic [ROW_W-1:0] src;
  logic [ROW_W-1:0] dst;
  logic [K_W-1:0]   k;
  logic             done_q;
  logic [K_W-1:0]   last_q;
  logic [15:0]      lines_q;
  logic [31:0]      score_q;

  logic [RW-1:0]    src_row;
  logic             src_full;
  logic [9:0]       base;
  logic [4:0]       lvl_p1;
  logic [13:0]      gain;
  logic [32:0]      score_sum;
  logic [16:0]      lines_sum;

  always_comb begin
    src_row  = board[src];
    src_full = 1'b1;
    for (int c = 0; c < BOARD_W; c++) begin
      if (src_row[c*CELL_W +: CELL_W] == '0) src_full = 1'b0;
    end
  end

  // Base points saturate at the four-line value for any larger clear.
  always_comb begin
    case (k)
      K_W'(0): base = 10'd0;
      K_W'(1): base = 10'd100;
      K_W'(2): base = 10'd300;
      K_W'(3): base = 10'd500;
      default: base = 10'd800;
    endcase
    lvl_p1    = {1'b0, bus.level} + 5'd1;
    gain      = 14'(base) * 14'(lvl_p1);
    score_sum = {1'b0, score_q} + 33'(gain);
    lines_sum = {1'b0, lines_q} + 17'(k);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      src     <= '0;
      dst     <= '0;
      k       <= '0;
      done_q  <= 1'b0;
      last_q  <= '0;
      lines_q <= '0;
      score_q <= '0;
      for (int r = 0; r < BOARD_H; r++) board[r] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.clear_board) begin
            for (int r = 0; r < BOARD_H; r++) board[r] <= '0;
          end else begin
            // The write lands on this edge, so a same-cycle scan sees it.
            if (bus.cell_we) begin
              for (int r = 0; r < BOARD_H; r++) begin
                for (int c = 0; c < BOARD_W; c++) begin
                  if (ROW_W'(r) == bus.cell_row && COL_W'(c) == bus.cell_col)
                    board[r][c*CELL_W +: CELL_W] <= bus.cell_val;
                end
              end
            end
            if (bus.clear_start) begin
              state <= SCAN;
              src   <= ROW_LAST;
              dst   <= ROW_LAST;
              k     <= '0;
            end
          end
        end
        SCAN: begin
          if (src_full) begin
            k <= k + K_W'(1);
          end else begin
            for (int r = 0; r < BOARD_H; r++) begin
              if (ROW_W'(r) == dst) board[r] <= src_row;
            end
            dst <= dst - ROW_W'(1);
          end
          src <= src - ROW_W'(1);
          if (src == '0) state <= (src_full || k != '0) ? FILL : SCORE;
        end
        // After the scan dst == k-1, so reaching row 0 means exactly k rows were blanked.
        FILL: begin
          for (int r = 0; r < BOARD_H; r++) begin
            if (ROW_W'(r) == dst) board[r] <= '0;
          end
          dst <= dst - ROW_W'(1);
          if (dst == '0) state <= SCORE;
        end
        SCORE: begin
          last_q  <= k;
          lines_q <= lines_sum[16] ? 16'hFFFF : lines_sum[15:0];
          score_q <= score_sum[32] ? 32'hFFFF_FFFF : score_sum[31:0];
          done_q  <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_data     = ({1'b0, bus.rd_row} < H_LIM) ? board[bus.rd_row] : '0;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.last_lines  = last_q;
  assign bus.lines_total = lines_q;
  assign bus.score       = score_q;
endmodule

// File: tb/tb_tetris_line_clear_engine.sv
// Bench for tetris_line_clear_engine: table vectors, directed corner sequences and random
// boards checked against a row-list model, plus a 6x8 variant.
module tb_tetris_line_clear_engine;
  localparam int W = 10, H = 20, CW = 4, RW = W * CW;
  localparam int SW = 6, SH = 8, SRW = SW * CW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tetris_line_clear_engine_if #(.BOARD_W(W), .BOARD_H(H), .CELL_W(CW)) d ();
  tetris_line_clear_engine_if #(.BOARD_W(SW), .BOARD_H(SH), .CELL_W(CW)) s ();

  tetris_line_clear_engine #(.BOARD_W(W), .BOARD_H(H), .CELL_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(d));
  tetris_line_clear_engine #(.BOARD_W(SW), .BOARD_H(SH), .CELL_W(CW)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(s));

  int checks = 0;
  int failures = 0;

  logic [RW-1:0] mb [H];
  longint m_score, m_lines;
  int m_last;

  typedef struct {
    int     nfull;
    int     lvl;
    int     exp_last;
    longint exp_gain;
  } vec_t;
  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic bit row_full(input logic [RW-1:0] row);
    for (int c = 0; c < W; c++) if (row[c*CW +: CW] == '0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic longint base_pts(input int kk);
    if (kk == 0) return 0;
    if (kk == 1) return 100;
    if (kk == 2) return 300;
    if (kk == 3) return 500;
    return 800;
  endfunction

  // Survivors keep their order and sink to the bottom; empties are stacked on top.
  task automatic model_clear(output int kk);
    logic [RW-1:0] keep[$];
    for (int r = 0; r < H; r++) if (!row_full(mb[r])) keep.push_back(mb[r]);
    kk = H - keep.size();
    for (int i = 0; i < kk; i++) keep.push_front(RW'(0));
    for (int r = 0; r < H; r++) mb[r] = keep[r];
  endtask

  task automatic check_board(input string tag);
    for (int r = 0; r < H; r++) begin
      d.rd_row = 5'(r);
      #1;
      check($sformatf("%s_row%0d", tag, r), 64'(d.rd_data), 64'(mb[r]));
    end
    tick();
  endtask

  task automatic write_cell(input int r, input int c, input int v);
    d.cell_we = 1'b1; d.cell_row = 5'(r); d.cell_col = 4'(c); d.cell_val = 4'(v);
    tick();
    d.cell_we = 1'b0;
    mb[r][c*CW +: CW] = 4'(v);
  endtask

  task automatic fill_row(input int r, input int v);
    for (int c = 0; c < W; c++) write_cell(r, c, v);
  endtask

  // clear_start and cell_we ride along and must be dropped.
  task automatic do_clear_board();
    d.clear_board = 1'b1; d.clear_start = 1'b1;
    d.cell_we = 1'b1; d.cell_row = 5'd0; d.cell_col = 4'd0; d.cell_val = 4'd5;
    tick();
    d.clear_board = 1'b0; d.clear_start = 1'b0; d.cell_we = 1'b0;
    for (int r = 0; r < H; r++) mb[r] = '0;
    check("clrb_busy", 64'(d.busy), 64'(0));
    d.rd_row = 5'd0;
    #1;
    check("clrb_row0", 64'(d.rd_data), 64'(0));
    check("clrb_score", 64'(d.score), 64'(m_score));
  endtask

  task automatic run_clear(input int lvl, input bit we, input int wr, input int wc, input int wv,
                           input bit poke, output int cyc);
    int kk;
    int ndone;
    d.level = 4'(lvl);
    d.clear_start = 1'b1;
    if (we) begin
      d.cell_we = 1'b1; d.cell_row = 5'(wr); d.cell_col = 4'(wc); d.cell_val = 4'(wv);
      mb[wr][wc*CW +: CW] = 4'(wv);
    end
    tick();
    d.clear_start = 1'b0; d.cell_we = 1'b0;
    model_clear(kk);
    m_last  = kk;
    m_lines = (m_lines + kk > 65535) ? 65535 : m_lines + kk;
    m_score = m_score + base_pts(kk) * (lvl + 1);
    if (m_score > 64'hFFFF_FFFF) m_score = 64'hFFFF_FFFF;
    cyc = 0;
    while (d.busy === 1'b1 && cyc < 400) begin
      cyc++;
      if (poke && cyc == 5) begin
        d.cell_we = 1'b1; d.cell_row = 5'd0; d.cell_col = 4'd0; d.cell_val = 4'd3;
      end
      if (poke && cyc == 6) begin d.cell_we = 1'b0; d.clear_start = 1'b1; end
      if (poke && cyc == 7) begin d.clear_start = 1'b0; d.clear_board = 1'b1; end
      if (poke && cyc == 8) d.clear_board = 1'b0;
      tick();
    end
    check("latency", 64'(cyc), 64'(H + kk + 1));
    check("done_pulse", 64'(d.done), 64'(1));
    check("last_lines", 64'(d.last_lines), 64'(m_last));
    check("lines_total", 64'(d.lines_total), 64'(m_lines));
    check("score", 64'(d.score), 64'(m_score));
    tick();
    check("done_low", 64'(d.done), 64'(0));
    if (poke) begin
      ndone = 0;
      repeat (25) begin
        tick();
        if (d.done) ndone++;
      end
      check("poke_no_done", 64'(ndone), 64'(0));
      check("poke_busy", 64'(d.busy), 64'(0));
    end
    check_board("post");
  endtask

  initial begin
    int cyc;
    int ndone;
    longint sc0;
    logic [SRW-1:0] srow [SH];

    vecs[0] = '{1, 0, 1, 100};
    vecs[1] = '{2, 1, 2, 600};
    vecs[2] = '{3, 2, 3, 1500};
    vecs[3] = '{4, 3, 4, 3200};
    vecs[4] = '{5, 15, 5, 12800};
    vecs[5] = '{0, 7, 0, 0};

    rst_n = 1'b0;
    d.cell_we = 1'b0; d.cell_row = '0; d.cell_col = '0; d.cell_val = '0;
    d.clear_start = 1'b0; d.clear_board = 1'b0; d.level = '0; d.rd_row = '0;
    s.cell_we = 1'b0; s.cell_row = '0; s.cell_col = '0; s.cell_val = '0;
    s.clear_start = 1'b0; s.clear_board = 1'b0; s.level = '0; s.rd_row = '0;
    m_score = 0; m_lines = 0; m_last = 0;
    for (int r = 0; r < H; r++) mb[r] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(d.busy), 64'(0));
    check("rst_done", 64'(d.done), 64'(0));
    check("rst_last", 64'(d.last_lines), 64'(0));
    check("rst_lines", 64'(d.lines_total), 64'(0));
    check("rst_score", 64'(d.score), 64'(0));
    rst_n = 1'b1;
    tick();
    check_board("rst");

    // Table: nfull bottom rows full, one stray cell above, fixed level.
    for (int i = 0; i < 6; i++) begin
      do_clear_board();
      for (int r = H - vecs[i].nfull; r < H; r++) fill_row(r, (r % 15) + 1);
      write_cell(H - vecs[i].nfull - 1, 0, 2);
      sc0 = m_score;
      run_clear(vecs[i].lvl, 1'b0, 0, 0, 0, 1'b0, cyc);
      check("tbl_last", 64'(d.last_lines), 64'(vecs[i].exp_last));
      check("tbl_score", 64'(d.score), 64'(sc0 + vecs[i].exp_gain));
      check("tbl_latency", 64'(cyc), 64'(H + vecs[i].exp_last + 1));
    end

    // Single bottom line; former row 18 drops to row 19.
    do_clear_board();
    fill_row(19, 1);
    write_cell(18, 3, 5);
    sc0 = m_score;
    run_clear(0, 1'b0, 0, 0, 0, 1'b0, cyc);
    check("one_latency", 64'(cyc), 64'(22));
    check("one_last", 64'(d.last_lines), 64'(1));
    check("one_score", 64'(d.score), 64'(sc0 + 100));
    d.rd_row = 5'd19; #1;
    check("one_row19", 64'(d.rd_data), 64'(40'h5000));

    // Rows 16,18,19 full with a lone cell in row 17, level 2.
    do_clear_board();
    fill_row(16, 3); fill_row(18, 4); fill_row(19, 6);
    write_cell(17, 4, 9);
    sc0 = m_score;
    run_clear(2, 1'b0, 0, 0, 0, 1'b0, cyc);
    check("three_last", 64'(d.last_lines), 64'(3));
    check("three_score", 64'(d.score), 64'(sc0 + 1500));
    d.rd_row = 5'd19; #1;
    check("three_row19", 64'(d.rd_data), 64'(40'h90000));

    // Empty board.
    do_clear_board();
    sc0 = m_score;
    run_clear(5, 1'b0, 0, 0, 0, 1'b0, cyc);
    check("empty_latency", 64'(cyc), 64'(21));
    check("empty_last", 64'(d.last_lines), 64'(0));
    check("empty_score", 64'(d.score), 64'(sc0));

    // Write and start in the same cycle; rows 6..19 full pull row 5 to the bottom.
    do_clear_board();
    for (int r = 6; r < H; r++) fill_row(r, 2);
    run_clear(0, 1'b1, 5, 2, 7, 1'b0, cyc);
    d.rd_row = 5'd19; #1;
    check("wr_start_row19", 64'(d.rd_data), 64'(40'h700));

    // Requests while busy are dropped.
    do_clear_board();
    fill_row(19, 8);
    write_cell(10, 6, 4);
    run_clear(1, 1'b0, 0, 0, 0, 1'b1, cyc);

    // Random boards with a bias towards full rows.
    for (int rnd = 0; rnd < 6; rnd++) begin
      int p;
      int v;
      do_clear_board();
      for (int r = 0; r < H; r++) begin
        p = int'($urandom_range(9, 0));
        for (int c = 0; c < W; c++) begin
          if (p < 4) v = int'($urandom_range(15, 1));
          else v = ($urandom_range(2, 0) == 0) ? 0 : int'($urandom_range(15, 1));
          if (v != 0) write_cell(r, c, v);
        end
      end
      run_clear(int'($urandom_range(15, 0)), 1'($urandom_range(1, 0)),
                int'($urandom_range(H - 1, 0)), int'($urandom_range(W - 1, 0)),
                int'($urandom_range(15, 1)), 1'b0, cyc);
    end

    // Reset in the middle of FILL.
    do_clear_board();
    for (int r = 15; r < H; r++) fill_row(r, 1);
    d.level = 4'd0;
    d.clear_start = 1'b1;
    tick();
    d.clear_start = 1'b0;
    repeat (H + 2) tick();
    check("midfill_busy", 64'(d.busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(d.busy), 64'(0));
    check("arst_done", 64'(d.done), 64'(0));
    check("arst_last", 64'(d.last_lines), 64'(0));
    check("arst_lines", 64'(d.lines_total), 64'(0));
    check("arst_score", 64'(d.score), 64'(0));
    for (int r = 0; r < H; r++) mb[r] = '0;
    m_score = 0; m_lines = 0; m_last = 0;
    check_board("arst");
    rst_n = 1'b1;
    ndone = 0;
    repeat (30) begin
      tick();
      if (d.done) ndone++;
    end
    check("arst_no_done", 64'(ndone), 64'(0));
    check("arst_idle", 64'(d.busy), 64'(0));

    // 6x8 variant, every cell occupied.
    for (int r = 0; r < SH; r++) srow[r] = '0;
    for (int r = 0; r < SH; r++) begin
      for (int c = 0; c < SW; c++) begin
        s.cell_we = 1'b1; s.cell_row = 3'(r); s.cell_col = 3'(c);
        s.cell_val = 4'($urandom_range(15, 1));
        srow[r][c*CW +: CW] = s.cell_val;
        tick();
      end
    end
    s.cell_we = 1'b0;
    for (int r = 0; r < SH; r++) begin
      s.rd_row = 3'(r); #1;
      check($sformatf("s_pre_row%0d", r), 64'(s.rd_data), 64'(srow[r]));
    end
    tick();
    s.level = 4'd0;
    s.clear_start = 1'b1;
    tick();
    s.clear_start = 1'b0;
    cyc = 0;
    while (s.busy === 1'b1 && cyc < 200) begin
      cyc++;
      tick();
    end
    check("s_latency", 64'(cyc), 64'(2 * SH + 1));
    check("s_done", 64'(s.done), 64'(1));
    check("s_last", 64'(s.last_lines), 64'(8));
    check("s_score", 64'(s.score), 64'(800));
    check("s_lines", 64'(s.lines_total), 64'(8));
    for (int r = 0; r < SH; r++) begin
      s.rd_row = 3'(r); #1;
      check($sformatf("s_post_row%0d", r), 64'(s.rd_data), 64'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tetris_line_clear_engine.md
TETRIS_LINE_CLEAR_ENGINE -- requirements
Module: tetris_line_clear_engine

Interface
REQ-001 SHALL have parameter BOARD_W, default 10, board columns (4..16).
REQ-002 SHALL have parameter BOARD_H, default 20, board rows (4..32).
REQ-003 SHALL have parameter CELL_W, default 4, bits per cell; value 0 = empty.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port cell_we  input  1  cell write strobe, honoured only in IDLE.
REQ-007 SHALL have port cell_row  input  $clog2(BOARD_H)  write row; 0 = top.
REQ-008 SHALL have port cell_col  input  $clog2(BOARD_W)  write column; 0 = left.
REQ-009 SHALL have port cell_val  input  CELL_W  value written.
REQ-010 SHALL have port clear_start  input  1  single-cycle request to scan and compact the board.
REQ-011 SHALL have port clear_board  input  1  zero the whole board, honoured only in IDLE.
REQ-012 SHALL have port level  input  4  score multiplier, sampled at SCORE.
REQ-013 SHALL have port rd_row  input  $clog2(BOARD_H)  renderer row select.
REQ-014 SHALL have port rd_data  output  BOARD_W*CELL_W  combinational contents of rd_row; column 0 in the LSBs.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse on the cycle after SCORE.
REQ-017 SHALL have port last_lines  output  $clog2(BOARD_H+1)  rows cleared by the most recent operation.
REQ-018 SHALL have port lines_total  output  16  cumulative cleared rows; saturates at 65535.
REQ-019 SHALL have port score  output  32  cumulative score; saturates at 2^32-1.

Function
REQ-020 SHALL implement FSM states IDLE, SCAN, FILL and SCORE.
REQ-021 SHALL go from IDLE to SCAN when clear_start=1 and clear_board=0.
REQ-022 SHALL load src=BOARD_H-1, dst=BOARD_H-1 and k=0 when entering SCAN.
REQ-023 SHALL handle one row per cycle in SCAN:
- a full row (every cell nonzero) increments k and leaves dst unchanged;
- otherwise row[dst] is loaded from row[src] and dst is decremented;
- src decrements every cycle.
REQ-024 SHALL leave SCAN after the cycle that handles src=0: go to FILL if k>0, else go to SCORE.
REQ-025 SHALL in FILL zero row[dst] and decrement dst, one row per cycle, for exactly k cycles, then go to SCORE.
REQ-026 SHALL in SCORE, in one cycle:
- set last_lines=k;
- add k to lines_total (saturating);
- add base(k)*(level+1) to score (saturating), where base is 0/100/300/500 for k=0/1/2/3 and 800 for k>=4;
- then return to IDLE.
REQ-027 SHALL give a total latency of BOARD_H+k+1 cycles from the clear_start sampling edge to the return to IDLE, with done asserted in the following cycle.
REQ-028 SHALL ignore clear_start, clear_board and cell_we while busy=1, with no queuing.
REQ-029 SHALL, in IDLE with clear_board=1, zero all cells in one cycle; in that cycle clear_start and cell_we are dropped; score and counters are unchanged.
REQ-030 SHALL, when cell_we and clear_start are both high in IDLE, commit the write in that cycle so that SCAN sees it.
REQ-031 SHALL produce last_lines=0, score unchanged and latency BOARD_H+1 when no row is full.
REQ-032 SHALL clear a fully occupied board to all-empty with k=BOARD_H.
REQ-033 SHALL make rd_data reflect partially compacted contents while busy; consumers sample it only when busy=0.

Reset
REQ-034 SHALL, while rst_n=0, asynchronously force:
- all cells=0, FSM=IDLE, busy=0, done=0;
- last_lines=0, lines_total=0, score=0;
- src, dst and k to 0.
REQ-035 SHALL abandon any in-progress operation on reset, with no done pulse.
REQ-036 SHALL resume in IDLE on the first rising clk edge after rst_n deasserts.

Verification
REQ-037 SHALL verify: row 19 filled with value 1, level=0, clear_start -> busy for 22 cycles (H+k+1 with k=1), then done; last_lines=1, score=100, row 19 holds the former row 18.
REQ-038 SHALL verify: rows 16, 18 and 19 full, one cell in row 17, level=2, clear_start -> last_lines=3, score=1500 (500*3), the lone cell moves to row 19, rows 0-18 empty.
REQ-039 SHALL verify: empty board, clear_start -> done after 21 cycles, last_lines=0, score=0.
REQ-040 SHALL verify: cell_we (row 5, col 2, value 7) and clear_start in the same cycle -> rd_row=19 shows value 7 at col 2 after done.
REQ-041 SHALL verify: rst_n pulsed low during FILL -> all outputs 0 immediately, board empty, no done pulse.
REQ-042 SHALL verify: clear_start and cell_we pulsed while busy -> ignored (board and done count unchanged); BOARD_W=6, BOARD_H=8 variant, all rows full -> last_lines=8, score=800.
